op_sequencer: RTL
=================

OP_SEQUENCER -- requirements
Module: op_sequencer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the op-word FIFO depth (power of 2, at least 2).
REQ-002 The block SHALL have parameter MM_CYCLES, default 96, meaning the number of cycles an opcode-1 (matmul) word is held on operation.
REQ-003 The block SHALL have parameter XFER_CYCLES, default 64, meaning the number of cycles an opcode-2 or opcode-3 (serial write/read) word is held.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: reset is synchronous and active-low.
REQ-006 The block SHALL have port enable, input, 1 bit: global enable; while low, all state SHALL be frozen.
REQ-007 The block SHALL have port op_valid, input, 1 bit: the host offers op_word.
REQ-008 The block SHALL have port op_ready, output, 1 bit: the FIFO accepts a word.
REQ-009 The block SHALL have port op_word, input, 32 bits: the operation word, with opcode in bits [3:0].
REQ-010 The block SHALL have port operation, output, 32 bits: the registered word driven to the matrix controller.
REQ-011 The block SHALL have port busy, output, 1 bit: the state is not IDLE or the FIFO is non-empty.
REQ-012 The block SHALL have port done, output, 1 bit: a one-cycle pulse when an issued word retires.
REQ-013 The block SHALL have port pending, output, log2(DEPTH)+1 bits: the FIFO occupancy.
REQ-014 The block SHALL have port err, output, 1 bit: a sticky illegal-opcode flag (see Configuration).

Function
REQ-015 op_ready SHALL equal enable AND (pending < DEPTH), with no combinational dependence on pop; a push occurs when op_valid and op_ready are both high.
REQ-016 The FIFO SHALL be first-in first-out; a simultaneous push and pop SHALL leave pending unchanged; pointers SHALL wrap modulo DEPTH.
REQ-017 The FSM SHALL have the states IDLE, RUN and GAP.
REQ-018 IDLE with pending != 0: on the clock edge the block SHALL pop the head, load operation with the head, load a down-counter with duration-1, and go to RUN.
REQ-019 Duration SHALL be MM_CYCLES for opcode 1, XFER_CYCLES for opcodes 2 and 3, and 1 for any other opcode.
REQ-020 RUN: operation SHALL be held constant; the counter SHALL decrement each enabled cycle; at counter == 0 the block SHALL go to GAP, with operation <= 0 and done <= 1.
REQ-021 GAP SHALL last one cycle, then the block SHALL go to IDLE with done <= 0.
REQ-022 An issued word SHALL therefore appear on operation for exactly duration cycles, and consecutive words SHALL be separated by exactly 2 cycles of operation == 0, so that the controller sees a fresh opcode rising edge.
REQ-023 IDLE with pending == 0: operation SHALL be 0 and no state change SHALL occur.
REQ-024 The down-counter SHALL be 16 bits; MM_CYCLES and XFER_CYCLES SHALL each be in 1..65535.
REQ-025 When enable is low: no push, no pop and no counter decrement SHALL occur, and operation, done, err and the state SHALL hold their values.

Reset
REQ-026 When reset is low at a clock edge, regardless of enable, the block SHALL set: operation = 0, state = IDLE, counter = 0, FIFO empty (pending = 0), done = 0, err = 0.
REQ-027 A reset asserted mid-RUN SHALL abort the word, discard all queued words, and produce no done pulse.
REQ-028 In the first cycle after reset is released, op_ready SHALL equal enable.

Configuration
REQ-029 With OP_SEQ_ILLEGAL_EN defined, a popped word with opcode > 3 SHALL NOT be issued: operation stays 0, err is set to 1 and stays set until reset, the block remains in IDLE, and done is not pulsed.
REQ-030 Without OP_SEQ_ILLEGAL_EN, a popped word with opcode > 3 SHALL be issued for 1 cycle like any other word, and err SHALL be tied to 0.

Verification
REQ-031 Push the word 0x00000001 with default parameters -> operation = 0x00000001 for exactly 96 cycles, then 0; done high for 1 cycle.
REQ-032 Push 0x00000013 then 0x00000023 back-to-back -> each word is held for 64 cycles; exactly 2 zero cycles lie between them; 2 done pulses.
REQ-033 Push 5 words with DEPTH=4 while the first is in RUN -> op_ready low with pending=4; the 5th word is accepted only after a pop; issue order is preserved.
REQ-034 Drop enable for 10 cycles during RUN -> operation and pending are unchanged; total hold time = 96 + 10 cycles.
REQ-035 Assert reset at cycle 40 of a matmul with 2 words queued -> the next cycle shows operation = 0, pending = 0, busy = 0, and no done pulse.
REQ-036 With OP_SEQ_ILLEGAL_EN defined, push 0x00000007 then 0x00000002 -> err = 1, 0x7 is never driven on operation, 0x2 is issued for 64 cycles.

Source files
------------

// File: rtl/op_sequencer.sv
// op_sequencer: FIFO-fed sequencer that holds each op word on operation for an opcode-dependent duration
// Ports: clk; reset (sync, active-low); enable (global freeze when low);
//   op_valid/op_ready/op_word: host push into the op-word FIFO;
//   operation: registered word to the matrix controller; busy: not idle or FIFO non-empty;
//   done: one-cycle retire pulse; pending: FIFO occupancy; err: sticky illegal-opcode flag.
// Define OP_SEQ_ILLEGAL_EN to drop opcodes > 3 and flag err; otherwise they issue for one cycle.
module op_sequencer #(
  parameter int DEPTH       = 4,
  parameter int MM_CYCLES   = 96,
  parameter int XFER_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   op_valid,
  output logic                   op_ready,
  input  logic [31:0]            op_word,
  output logic [31:0]            operation,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(DEPTH):0] pending,
  output logic                   err
);
  localparam int PW = $clog2(DEPTH);
`ifdef OP_SEQ_ILLEGAL_EN
  localparam bit ILLEGAL_EN = 1'b1;
`else
  localparam bit ILLEGAL_EN = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;
  state_t        state_q, state_d;
  logic [31:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic [15:0]   tmr_q, tmr_d;
  logic [31:0]   op_q, op_d;
  logic          done_q, done_d, err_q, err_d;
  logic          push, pop, bad;
  logic [31:0]   head;
  function automatic logic [15:0] dur_m1(input logic [3:0] opc);
    return opc == 4'd1 ? 16'(MM_CYCLES - 1) :
           (opc == 4'd2 || opc == 4'd3) ? 16'(XFER_CYCLES - 1) : 16'd0;
  endfunction
  // DEPTH is a power of two, so occupancy < DEPTH exactly when the MSB is clear
  assign op_ready  = enable && !cnt_q[PW];
  assign operation = op_q;
  assign done      = done_q;
  assign pending   = cnt_q;
  assign busy      = state_q != IDLE || cnt_q != '0;
  assign err       = ILLEGAL_EN ? err_q : 1'b0;
  always_comb begin
    head    = mem_q[rd_q];
    push    = op_valid && op_ready;
    pop     = enable && state_q == IDLE && cnt_q != '0;
    bad     = ILLEGAL_EN && head[3:0] > 4'd3;
    wr_d    = wr_q + PW'(push);
    rd_d    = rd_q + PW'(pop);
    cnt_d   = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    state_d = state_q;
    op_d    = op_q;
    tmr_d   = tmr_q;
    done_d  = done_q;
    err_d   = err_q || (pop && bad);
    if (enable)
      case (state_q)
        IDLE: if (pop && !bad) begin
          state_d = RUN;
          op_d    = head;
          tmr_d   = dur_m1(head[3:0]);
        end
        RUN: if (tmr_q == '0) begin
          state_d = GAP;
          op_d    = '0;
          done_d  = 1'b1;
        end else tmr_d = tmr_q - 16'd1;
        GAP: begin
          state_d = IDLE;
          done_d  = 1'b0;
        end
        default: state_d = IDLE;
      endcase
  end
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= op_word;
  always_ff @(posedge clk)
    if (!reset) begin
      state_q <= IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      tmr_q   <= '0;
      op_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      op_q    <= op_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
endmodule
